// File: rtl/batch_collector.sv
// -----------------------------------------------------------------------------
// batch_collector
//
// Sits behind the conflict checker. It gathers conflict-free transactions into
// a batch, keeps the union of their read/write dependency sets, and closes the
// batch when it is full, when it times out, or when flush is raised. The batch
// is then streamed out one program ID per beat. After the last beat a one-cycle
// batch_completed pulse tells the conflict checker to clear its tracking.
//
// Optional feature macro: BATCH_COLLECTOR_CONFLICT_CHECK_EN
//   defined   -> conflict_error goes high (sticky) if an accepted transaction
//                overlaps the batch's accumulated sets (RAW/WAR/WAW)
//   undefined -> conflict_error is tied to 0
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_axis_tvalid / s_axis_tready     input stream handshake
//   s_axis_tdata_owner_programID      transaction program ID
//   s_axis_tdata_read_dependencies    transaction read set
//   s_axis_tdata_write_dependencies   transaction write set
//   flush                             level; close a non-empty batch early
//   m_axis_tvalid / m_axis_tready     output stream handshake
//   m_axis_tdata_programID            program ID of the current beat
//   m_axis_tlast                      last beat of the batch
//   m_batch_size                      transaction count of the emitted batch
//   m_batch_read/write_dependencies   union sets of the emitted batch
//   batch_completed                   one-cycle pulse after the batch drained
//   batches_emitted, txns_collected   free-running 32-bit counters
//   conflict_error                    sticky intra-batch conflict flag
// -----------------------------------------------------------------------------
module batch_collector #(
  parameter int MAX_BATCH_SIZE = 8,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int ID_WIDTH       = 64,
  parameter int DEP_WIDTH      = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [ID_WIDTH-1:0]                   s_axis_tdata_owner_programID,
  input  logic [DEP_WIDTH-1:0]                  s_axis_tdata_read_dependencies,
  input  logic [DEP_WIDTH-1:0]                  s_axis_tdata_write_dependencies,
  input  logic                                  flush,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [ID_WIDTH-1:0]                   m_axis_tdata_programID,
  output logic                                  m_axis_tlast,
  output logic [$clog2(MAX_BATCH_SIZE+1)-1:0]   m_batch_size,
  output logic [DEP_WIDTH-1:0]                  m_batch_read_dependencies,
  output logic [DEP_WIDTH-1:0]                  m_batch_write_dependencies,
  output logic                                  batch_completed,
  output logic [31:0]                           batches_emitted,
  output logic [31:0]                           txns_collected,
  output logic                                  conflict_error
);

  localparam int CNT_W = $clog2(MAX_BATCH_SIZE + 1);
  localparam int IDX_W = $clog2(MAX_BATCH_SIZE);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {COLLECT, EMIT, DONE} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     rd_idx_q;
  logic [TMR_W-1:0]     timer_q;
  logic [DEP_WIDTH-1:0] union_rd_q;
  logic [DEP_WIDTH-1:0] union_wr_q;
  logic [31:0]          batches_q;
  logic [31:0]          txns_q;
  logic [ID_WIDTH-1:0]  id_buf_q [MAX_BATCH_SIZE];

  logic             accept;
  logic [CNT_W-1:0] count_d;
  logic             close_batch;
  logic             last_beat;
  logic             emitting;

  assign emitting      = (state_q == EMIT);
  assign s_axis_tready = (state_q == COLLECT) && (count_q < CNT_W'(MAX_BATCH_SIZE));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign count_d       = count_q + {{(CNT_W-1){1'b0}}, accept};
  assign last_beat     = (rd_idx_q == count_q - CNT_W'(1));

  // count_d includes a same-cycle accept, so the closing transaction is part
  // of the batch. An empty batch never closes.
  assign close_batch = (count_d == CNT_W'(MAX_BATCH_SIZE))
                    || ((count_q != '0) && (timer_q >= TMR_W'(TIMEOUT_CYCLES - 1)))
                    || (flush && (count_d != '0));

  // Outputs decode registered state only; they read zero outside EMIT.
  assign m_axis_tvalid              = emitting;
  assign m_axis_tdata_programID     = emitting ? id_buf_q[rd_idx_q[IDX_W-1:0]] : '0;
  assign m_axis_tlast               = emitting && last_beat;
  assign m_batch_size               = emitting ? count_q : '0;
  assign m_batch_read_dependencies  = emitting ? union_rd_q : '0;
  assign m_batch_write_dependencies = emitting ? union_wr_q : '0;
  assign batch_completed            = (state_q == DONE);
  assign batches_emitted            = batches_q;
  assign txns_collected             = txns_q;

  // NOTE: the ID buffer has no reset; its entries are only read below count_q,
  // so stale contents are never observed and reset fan-out stays off the array.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_buf_q[count_q[IDX_W-1:0]] <= s_axis_tdata_owner_programID;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      count_q    <= '0;
      rd_idx_q   <= '0;
      timer_q    <= '0;
      union_rd_q <= '0;
      union_wr_q <= '0;
      batches_q  <= '0;
      txns_q     <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          // Timer sits at zero while empty, so the first accept starts it
          // from zero; it then counts every cycle the batch is non-empty.
          if (count_q == '0) begin
            timer_q <= '0;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + TMR_W'(1);
          end
          if (accept) begin
            count_q    <= count_d;
            union_rd_q <= union_rd_q | s_axis_tdata_read_dependencies;
            union_wr_q <= union_wr_q | s_axis_tdata_write_dependencies;
            txns_q     <= txns_q + 32'd1;
          end
          if (close_batch) begin
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (m_axis_tready) begin
            rd_idx_q <= rd_idx_q + CNT_W'(1);
            if (last_beat) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          count_q    <= '0;
          rd_idx_q   <= '0;
          timer_q    <= '0;
          union_rd_q <= '0;
          union_wr_q <= '0;
          batches_q  <= batches_q + 32'd1;
          state_q    <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

`ifdef BATCH_COLLECTOR_CONFLICT_CHECK_EN
  // Compared against the union before this accept, so a transaction never
  // conflicts with itself.
  logic conflict_q;
  logic overlap;

  assign overlap = |(s_axis_tdata_write_dependencies & union_wr_q)
                || |(s_axis_tdata_read_dependencies  & union_wr_q)
                || |(s_axis_tdata_write_dependencies & union_rd_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
    end else if (accept && overlap) begin
      conflict_q <= 1'b1;
    end
  end

  assign conflict_error = conflict_q;
`else
  assign conflict_error = 1'b0;
`endif

endmodule

// File: tb/tb_batch_collector.sv
// -----------------------------------------------------------------------------
// tb_batch_collector
//
// Directed bench for batch_collector. The stimulus pushes the expected output
// beats of each batch into a scoreboard queue; an independent monitor pops and
// compares on every output handshake, and also watches backpressure stability,
// input blocking during EMIT/DONE, idle outputs and batch_completed timing.
// -----------------------------------------------------------------------------
module tb_batch_collector;

  localparam int MAX_BATCH = 8;
  localparam int TIMEOUT   = 100;
  localparam int IDW       = 16;
  localparam int DEPW      = 32;

  typedef struct {
    logic [IDW-1:0]  id;
    logic            last;
    logic [3:0]      size;
    logic [DEPW-1:0] rd;
    logic [DEPW-1:0] wr;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [IDW-1:0]  s_id;
  logic [DEPW-1:0] s_rd;
  logic [DEPW-1:0] s_wr;
  logic            flush;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [IDW-1:0]  m_id;
  logic            m_axis_tlast;
  logic [3:0]      m_batch_size;
  logic [DEPW-1:0] m_rd;
  logic [DEPW-1:0] m_wr;
  logic            batch_completed;
  logic [31:0]     batches_emitted;
  logic [31:0]     txns_collected;
  logic            conflict_error;

  batch_collector #(
    .MAX_BATCH_SIZE(MAX_BATCH),
    .TIMEOUT_CYCLES(TIMEOUT),
    .ID_WIDTH(IDW),
    .DEP_WIDTH(DEPW)
  ) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .s_axis_tvalid                   (s_axis_tvalid),
    .s_axis_tready                   (s_axis_tready),
    .s_axis_tdata_owner_programID    (s_id),
    .s_axis_tdata_read_dependencies  (s_rd),
    .s_axis_tdata_write_dependencies (s_wr),
    .flush                           (flush),
    .m_axis_tvalid                   (m_axis_tvalid),
    .m_axis_tready                   (m_axis_tready),
    .m_axis_tdata_programID          (m_id),
    .m_axis_tlast                    (m_axis_tlast),
    .m_batch_size                    (m_batch_size),
    .m_batch_read_dependencies       (m_rd),
    .m_batch_write_dependencies      (m_wr),
    .batch_completed                 (batch_completed),
    .batches_emitted                 (batches_emitted),
    .txns_collected                  (txns_collected),
    .conflict_error                  (conflict_error)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks   = 0;
  int    failures = 0;
  beat_t sb[$];

  int unsigned exp_batches = 0;
  int unsigned exp_txns    = 0;
  logic        exp_conf    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic           last_hs = 1'b0;
  logic           stalled = 1'b0;
  logic [IDW-1:0] held_id;
  logic           held_last;
  logic [3:0]     held_size;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_hs = 1'b0;
      stalled = 1'b0;
    end else begin
      check("batch_completed_timing", batch_completed, last_hs);
      if (m_axis_tvalid || batch_completed)
        check("s_tready_blocked", s_axis_tready, 1'b0);
      if (!m_axis_tvalid)
        check("idle_batch_outputs", {m_batch_size, m_rd, m_wr}, '0);
      if (stalled) begin
        check("stall_valid_held", m_axis_tvalid, 1'b1);
        check("stall_id_held", m_id, held_id);
        check("stall_last_held", m_axis_tlast, held_last);
        check("stall_size_held", m_batch_size, held_size);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", m_id, '1);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("beat_id", m_id, e.id);
          check("beat_last", m_axis_tlast, e.last);
          check("beat_size", m_batch_size, e.size);
          check("beat_rd_union", m_rd, e.rd);
          check("beat_wr_union", m_wr, e.wr);
        end
      end
      last_hs   = m_axis_tvalid && m_axis_tready && m_axis_tlast;
      stalled   = m_axis_tvalid && !m_axis_tready;
      held_id   = m_id;
      held_last = m_axis_tlast;
      held_size = m_batch_size;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IDW-1:0] id, input logic [DEPW-1:0] rd, input logic [DEPW-1:0] wr);
    int w;
    s_axis_tvalid = 1'b1;
    s_id = id;
    s_rd = rd;
    s_wr = wr;
    w = 0;
    while (!s_axis_tready && w < 300) begin
      tick();
      w++;
    end
    if (!s_axis_tready) begin
      check("send_wait_tready", 1'b0, 1'b1);
    end else begin
      tick();
      exp_txns++;
    end
    s_axis_tvalid = 1'b0;
  endtask

  // Transaction i of a batch reads bit 2i and writes bit 2i+1: no overlaps.
  task automatic send_std(input logic [IDW-1:0] base, input int n);
    for (int i = 0; i < n; i++)
      send(base + IDW'(i), DEPW'(1) << (2 * i), DEPW'(1) << (2 * i + 1));
  endtask

  task automatic push_beats(input logic [IDW-1:0] base, input int n,
                            input logic [DEPW-1:0] rdu, input logic [DEPW-1:0] wru);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.id   = base + IDW'(i);
      b.last = (i == n - 1);
      b.size = 4'(n);
      b.rd   = rdu;
      b.wr   = wru;
      sb.push_back(b);
    end
  endtask

  task automatic drain(input bit bp);
    int w;
    w = 0;
    while (!batch_completed && w < 400) begin
      tick();
      if (bp) m_axis_tready = ~m_axis_tready;
      w++;
    end
    check("batch_completed_seen", batch_completed, 1'b1);
    if (batch_completed) exp_batches++;
    tick();
    check("batches_emitted", batches_emitted, 64'(exp_batches));
    check("txns_collected", txns_collected, 64'(exp_txns));
    check("conflict_error", conflict_error, exp_conf);
    check("sb_drained", 64'(sb.size()), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned t0;
    int          w;

    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_id          = '0;
    s_rd          = '0;
    s_wr          = '0;
    flush         = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_s_tready", s_axis_tready, 1'b1);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_batch_completed", batch_completed, 1'b0);
    check("rst_batches_emitted", batches_emitted, 0);
    check("rst_txns_collected", txns_collected, 0);
    check("rst_conflict_error", conflict_error, 1'b0);

    // Full batch of 8, no backpressure.
    push_beats(16'h0001, 8, 32'h5555, 32'hAAAA);
    send_std(16'h0001, 8);
    drain(1'b0);

    // Timeout: 3 transactions then idle.
    push_beats(16'h000A, 3, 32'h15, 32'h2A);
    send(16'h000A, 32'h1, 32'h2);
    t0 = cyc;
    send(16'h000B, 32'h4, 32'h8);
    send(16'h000C, 32'h10, 32'h20);
    w = 0;
    while (!m_axis_tvalid && w < 200) begin
      tick();
      w++;
    end
    check("timeout_latency", 64'(cyc - t0), 64'(TIMEOUT));
    drain(1'b0);

    // Backpressure: ready toggles while draining a full batch.
    m_axis_tready = 1'b0;
    push_beats(16'h0010, 8, 32'h5555, 32'hAAAA);
    send_std(16'h0010, 8);
    drain(1'b1);
    m_axis_tready = 1'b1;

    // Flush on an empty batch is ignored.
    flush = 1'b1;
    repeat (5) tick();
    check("flush_empty_no_valid", m_axis_tvalid, 1'b0);
    check("flush_empty_tready", s_axis_tready, 1'b1);
    flush = 1'b0;

    // Flush after 2 accepts.
    push_beats(16'h0030, 2, 32'h5, 32'hA);
    send_std(16'h0030, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain(1'b0);

    // Flush coincident with the 3rd accept.
    push_beats(16'h0040, 3, 32'h15, 32'h2A);
    send_std(16'h0040, 2);
    flush = 1'b1;
    send(16'h0042, 32'h10, 32'h20);
    flush = 1'b0;
    drain(1'b0);

    // Reset in the middle of emitting a 5-beat batch.
    m_axis_tready = 1'b0;
    push_beats(16'h0060, 5, 32'h155, 32'h2AA);
    send_std(16'h0060, 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("pre_reset_emit_valid", m_axis_tvalid, 1'b1);
    m_axis_tready = 1'b1;
    tick();
    tick();
    check("pre_reset_remaining_beats", 64'(sb.size()), 3);
    m_axis_tready = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    exp_batches = 0;
    exp_txns    = 0;
    exp_conf    = 1'b0;
    #1;
    check("midrst_m_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_batch_completed", batch_completed, 1'b0);
    check("midrst_batches", batches_emitted, 0);
    check("midrst_txns", txns_collected, 0);
    check("midrst_batch_outputs", {m_id, m_batch_size, m_rd, m_wr}, '0);
    tick();
    tick();
    check("inrst_batch_completed", batch_completed, 1'b0);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    push_beats(16'h0020, 8, 32'h5555, 32'hAAAA);
    send_std(16'h0020, 8);
    drain(1'b0);

    // Intra-batch overlap: txn1 writes bit 5, txn2 reads bit 5.
    push_beats(16'h0050, 2, 32'h20, 32'h20);
    send(16'h0050, 32'h0, 32'h20);
    send(16'h0051, 32'h20, 32'h0);
`ifdef BATCH_COLLECTOR_CONFLICT_CHECK_EN
    exp_conf = 1'b1;
`endif
    check("conflict_after_accept", conflict_error, exp_conf);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain(1'b0);
    repeat (3) tick();
    check("conflict_sticky", conflict_error, exp_conf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/batch_collector.md
Name: batch_collector

Overview:
Downstream consumer of the conflict checker's AXI-Stream output. Accumulates conflict-free transactions into a batch, tracks the batch's union read/write dependency sets, and closes the batch when it is full, timed out, or flushed. Drains the batch as a stream of program IDs to the scheduler/executor, then pulses batch_completed back to the conflict checker so it clears its batch dependency tracking.

Parameters:
MAX_BATCH_SIZE, 8, max transactions per batch (>=2); buffer depth
TIMEOUT_CYCLES, 100, cycles from first accept in a batch until forced close (>=1)
ID_WIDTH, 64, program ID width
DEP_WIDTH, 1024, dependency bitmap width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
s_axis_tvalid  input  1  transaction valid from conflict checker
s_axis_tready  output  1  ready to conflict checker
s_axis_tdata_owner_programID  input  ID_WIDTH  transaction program ID
s_axis_tdata_read_dependencies  input  DEP_WIDTH  transaction read set
s_axis_tdata_write_dependencies  input  DEP_WIDTH  transaction write set
flush  input  1  level; close current non-empty batch early
m_axis_tvalid  output  1  batch beat valid
m_axis_tready  input  1  downstream ready
m_axis_tdata_programID  output  ID_WIDTH  program ID of current beat
m_axis_tlast  output  1  last beat of batch
m_batch_size  output  clog2(MAX_BATCH_SIZE+1)  transaction count of batch being emitted
m_batch_read_dependencies  output  DEP_WIDTH  union read set of batch
m_batch_write_dependencies  output  DEP_WIDTH  union write set of batch
batch_completed  output  1  one-cycle pulse to conflict checker after batch drained
batches_emitted  output  32  completed batch counter
txns_collected  output  32  accepted transaction counter
conflict_error  output  1  sticky intra-batch conflict flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state COLLECT; count=0, rd_idx=0, timer=0; union sets 0; all outputs 0 (s_axis_tready follows its combinational equation -> 1 after reset release).
- States: COLLECT, EMIT, DONE.
- s_axis_tready combinational = (state==COLLECT) && (count<MAX_BATCH_SIZE). Accept = s_axis_tvalid && s_axis_tready.
- COLLECT, on accept: buf[count]<=ID; count++; union_read|=read set; union_write|=write set; txns_collected++ (wraps at 2^32).
- Timer: cleared to 0 on the accept taking count 0->1; increments each COLLECT cycle while count>0; saturates.
- Close condition (evaluated per COLLECT cycle, using count_next = count+accept): count_next==MAX_BATCH_SIZE, or (count>0 && timer>=TIMEOUT_CYCLES-1), or (flush && count_next>0). Close -> EMIT next cycle; a same-cycle accept is included in the batch.
- Empty batch never closes; flush with count_next==0 ignored; timer idle at count 0.
- EMIT: m_axis_tvalid=1; m_axis_tdata_programID=buf[rd_idx]; m_axis_tlast=(rd_idx==count-1); m_batch_size=count; union outputs = accumulated sets, stable for whole EMIT. On m_axis_tvalid&&m_axis_tready: rd_idx++; if tlast -> DONE. Under backpressure all m_* outputs held stable (AXI-S rules); valid never deasserts before handshake.
- Latency: closing accept -> first m_axis_tvalid = 1 cycle. Last m handshake -> batch_completed high the following cycle (DONE state, exactly one cycle).
- DONE: batch_completed=1; m_axis_tvalid=0; batches_emitted++ (wraps); count, rd_idx, timer, union sets cleared; -> COLLECT. s_axis_tready=0 in EMIT and DONE, so no transaction is ever accepted against stale checker state.
- m_batch_size and union outputs read 0 outside EMIT.
- Reset mid-EMIT: batch discarded, no batch_completed pulse; counters reset to 0.

Optional Feature:
BATCH_COLLECTOR_CONFLICT_CHECK_EN: defined -> on each accept, if (write & union_write)!=0 or (read & union_write)!=0 or (write & union_read)!=0 against pre-accept union sets, conflict_error<=1 (sticky until reset); transaction still accepted. Undefined -> conflict_error tied 0, no comparison logic synthesized.

Test Plan:
- Full batch: 8 accepts IDs 1..8, disjoint deps, m_axis_tready=1 -> beats 1..8, tlast only on ID 8, m_batch_size=8, batch_completed one pulse cycle after beat 8, batches_emitted=1, txns_collected=8.
- Timeout: 3 accepts (IDs 0xA,0xB,0xC) then idle -> m_axis_tvalid rises 100 cycles after first accept, 3 beats, tlast on 0xC, m_batch_size=3.
- Backpressure: full batch, m_axis_tready toggling 1/0 -> every beat held stable while stalled, all 8 IDs in order, s_axis_tready=0 throughout EMIT/DONE.
- Flush: flush=1 at count=0 -> stays COLLECT, no output; 2 accepts then flush=1 -> 2-beat batch; flush coincident with 3rd accept -> 3-beat batch.
- Reset mid-EMIT after beat 2 of 5 -> all outputs 0, no batch_completed; next 8 accepts form fresh batch starting at buf[0].
- With BATCH_COLLECTOR_CONFLICT_CHECK_EN: txn1 write bit 5, txn2 read bit 5 -> conflict_error=1 and remains 1 after batch completes; without macro -> stays 0.
